// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//
// ID-stage branch/jump resolution for the pipelined MIPS core. Sits directly
// downstream of the branch comparator: chooses the comparator mode, waits
// (stalling ID) until forwarded operands are valid, decides taken/not-taken,
// and issues a one-cycle PC redirect plus IF/ID flush with the target.
//
// Parameters:
//   WAIT_MAX     maximum consecutive operand-wait cycles before hazard_err
//
// Ports:
//   clk          core clock, rising-edge
//   rst          synchronous active-high reset
//   id_valid     ID slot holds a valid instruction
//   id_pc        PC of the instruction in ID
//   br_type      0 none, 1 beq, 2 bne, 3 bltz, 4 bgez, 5 j, 6-7 none
//   id_jidx      instruction bits [25:0] ([15:0] = branch offset)
//   ops_ready    forwarded comparator operands valid this cycle
//   zero/one     comparator equal / not-equal results
//   cmp_out      comparator sign-test result for the selected mode
//   cmp_sel      comparator mode (1 for bgez), combinational
//   stall_id     hold PC and IF/ID, combinational
//   redirect     load pc_target into PC, registered, one cycle wide
//   flush_ifid   squash IF/ID, registered, identical to redirect
//   pc_target    redirect address, registered
//   hazard_err   sticky: operand wait exceeded WAIT_MAX
//   br_count     resolved conditional branches (stats build only)
//   taken_count  taken conditional branches (stats build only)
//
// Handshake: an instruction is consumed when id_valid=1 and stall_id=0 in a
// cycle the FSM is not in REDIRECT; the slot seen during REDIRECT is the
// squashed one and is ignored.
//
// Optional feature macro: BRANCH_RESOLVE_STATS_EN (branch statistics
// counters). Without it br_count and taken_count are tied to 0.
// ---------------------------------------------------------------------------
module branch_resolve #(
   parameter int WAIT_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [2:0]  br_type,
   input  logic [25:0] id_jidx,
   input  logic        ops_ready,
   input  logic        zero,
   input  logic        one,
   input  logic        cmp_out,
   output logic        cmp_sel,
   output logic        stall_id,
   output logic        redirect,
   output logic        flush_ifid,
   output logic [31:0] pc_target,
   output logic        hazard_err,
   output logic [31:0] br_count,
   output logic [31:0] taken_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT     = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   localparam logic [31:0] WAIT_LIM = 32'(WAIT_MAX);

   state_t      state, state_next;
   logic [31:0] wait_cnt;

   logic        is_cond, is_jump, cond_taken;
   logic        resolve_cond, jump_go, take;
   logic        wait_start, wait_inc;
   logic        stall_raw;
   logic [31:0] pc_plus4, br_target, jmp_target, tgt;

   // Instruction decode and condition evaluation
   always_comb begin
      is_cond    = (br_type >= 3'd1) && (br_type <= 3'd4);
      is_jump    = (br_type == 3'd5);
      cond_taken = 1'b0;
      case (br_type)
         3'd1:    cond_taken = zero;
         3'd2:    cond_taken = one;
         3'd3,
         3'd4:    cond_taken = cmp_out;
         default: cond_taken = 1'b0;
      endcase
   end

   // Targets wrap modulo 2^32 by construction of 32-bit adds
   always_comb begin
      pc_plus4   = id_pc + 32'd4;
      br_target  = pc_plus4 + {{14{id_jidx[15]}}, id_jidx[15:0], 2'b00};
      jmp_target = {pc_plus4[31:28], id_jidx, 2'b00};
      tgt        = is_jump ? jmp_target : br_target;
   end

   // Next-state logic
   always_comb begin
      state_next   = state;
      stall_raw    = 1'b0;
      resolve_cond = 1'b0;
      jump_go      = 1'b0;
      wait_start   = 1'b0;
      wait_inc     = 1'b0;
      case (state)
         S_IDLE: begin
            if (id_valid) begin
               if (is_jump) begin
                  jump_go = 1'b1;
               end else if (is_cond) begin
                  if (ops_ready) begin
                     resolve_cond = 1'b1;
                  end else begin
                     stall_raw  = 1'b1;
                     wait_start = 1'b1;
                     state_next = S_WAIT;
                  end
               end
            end
         end
         S_WAIT: begin
            // An external flush (id_valid drop) abandons the wait silently
            if (!id_valid || !(is_cond || is_jump)) begin
               state_next = S_IDLE;
            end else if (is_jump) begin
               jump_go    = 1'b1;
               state_next = S_IDLE;
            end else if (ops_ready) begin
               resolve_cond = 1'b1;
               state_next   = S_IDLE;
            end else begin
               stall_raw = 1'b1;
               wait_inc  = 1'b1;
            end
         end
         S_REDIRECT: begin
            // Slot in ID now is the squashed one: no resolve, no stall
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      take = jump_go || (resolve_cond && cond_taken);
      if (take) state_next = S_REDIRECT;
   end

   assign stall_id = stall_raw && !rst;
   assign cmp_sel  = (br_type == 3'd4) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         redirect   <= 1'b0;
         flush_ifid <= 1'b0;
         pc_target  <= '0;
         hazard_err <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         state      <= state_next;
         redirect   <= take;
         flush_ifid <= take;
         if (take) pc_target <= tgt;
         if (wait_start) begin
            wait_cnt <= 32'd1;
         end else if (wait_inc) begin
            // Saturate just above the limit so a long wait cannot wrap
            if (wait_cnt <= WAIT_LIM) wait_cnt <= wait_cnt + 32'd1;
            if (wait_cnt >= WAIT_LIM) hazard_err <= 1'b1;
         end else if (state_next != S_WAIT) begin
            wait_cnt <= '0;
         end
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] br_cnt_q, taken_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
      end else if (resolve_cond) begin
         br_cnt_q <= br_cnt_q + 32'd1;
         if (cond_taken) taken_cnt_q <= taken_cnt_q + 32'd1;
      end
   end

   assign br_count    = br_cnt_q;
   assign taken_count = taken_cnt_q;
`else
   assign br_count    = '0;
   assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//
// Self-checking bench for branch_resolve. Expected redirect targets go into
// exp_q when a taken branch/jump is driven; a negedge monitor pops and
// compares them whenever redirect is high. Scenario tasks check the
// combinational and registered outputs inline.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [2:0]  br_type;
   logic [25:0] id_jidx;
   logic        ops_ready;
   logic        zero;
   logic        one;
   logic        cmp_out;
   logic        cmp_sel;
   logic        stall_id;
   logic        redirect;
   logic        flush_ifid;
   logic [31:0] pc_target;
   logic        hazard_err;
   logic [31:0] br_count;
   logic [31:0] taken_count;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] m_br = 0;
   logic [31:0] m_taken = 0;
   logic        prev_redirect = 1'b0;

   branch_resolve #(.WAIT_MAX(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .br_type    (br_type),
      .id_jidx    (id_jidx),
      .ops_ready  (ops_ready),
      .zero       (zero),
      .one        (one),
      .cmp_out    (cmp_out),
      .cmp_sel    (cmp_sel),
      .stall_id   (stall_id),
      .redirect   (redirect),
      .flush_ifid (flush_ifid),
      .pc_target  (pc_target),
      .hazard_err (hazard_err),
      .br_count   (br_count),
      .taken_count(taken_count)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model helpers ----------------
   function automatic logic [31:0] exp_br_cnt();
`ifdef BRANCH_RESOLVE_STATS_EN
      return m_br;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_taken_cnt();
`ifdef BRANCH_RESOLVE_STATS_EN
      return m_taken;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] model_br_tgt(input logic [31:0] pc, input logic [15:0] off);
      logic [31:0] s;
      s = {{16{off[15]}}, off};
      return pc + 32'd4 + (s << 2);
   endfunction

   function automatic logic [31:0] model_j_tgt(input logic [31:0] pc, input logic [25:0] idx);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      return {p4[31:28], idx, 2'b00};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc, input logic [2:0] t,
                         input logic [25:0] j, input logic rdy, input logic z,
                         input logic o, input logic c);
      id_valid  = v;
      id_pc     = pc;
      br_type   = t;
      id_jidx   = j;
      ops_ready = rdy;
      zero      = z;
      one       = o;
      cmp_out   = c;
   endtask

   task automatic idle_in();
      set_in(1'b0, 32'd0, 3'd0, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      checks++;
      if (flush_ifid !== redirect) begin
         errors++;
         $display("FAIL flush_eq_redirect: flush_ifid=%b redirect=%b", flush_ifid, redirect);
      end
      if (redirect === 1'b1) begin
         checks++;
         if (prev_redirect) begin
            errors++;
            $display("FAIL redirect_width: redirect high two cycles in a row");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_redirect: pc_target=%h with no expected redirect", pc_target);
         end else begin
            e = exp_q.pop_front();
            if (pc_target !== e) begin
               errors++;
               $display("FAIL sb_target: got %h expected %h", pc_target, e);
            end
         end
      end
      prev_redirect = (redirect === 1'b1);
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 32'h100, 3'd4, 26'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checks++;
      if (stall_id !== 1'b0 || cmp_sel !== 1'b0) begin
         errors++;
         $display("FAIL reset_comb: stall_id=%b cmp_sel=%b expected 0 0", stall_id, cmp_sel);
      end
      checks++;
      if (redirect !== 1'b0 || flush_ifid !== 1'b0 || pc_target !== 32'd0 || hazard_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: redirect=%b flush=%b pc_target=%h hazard=%b expected 0 0 0 0",
                  redirect, flush_ifid, pc_target, hazard_err);
      end
      checks++;
      if (br_count !== 32'd0 || taken_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_counts: br=%0d taken=%0d expected 0 0", br_count, taken_count);
      end
      rst = 1'b0;
      idle_in();
      m_br = 0;
      m_taken = 0;
      tick();
   endtask

   task automatic test_beq_taken();
      set_in(1'b1, 32'h0040_0010, 3'd1, 26'h0004, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(32'h0040_0024);
      m_br++;
      m_taken++;
      #1;
      checks++;
      if (stall_id !== 1'b0 || cmp_sel !== 1'b0) begin
         errors++;
         $display("FAIL beq_comb: stall_id=%b cmp_sel=%b expected 0 0", stall_id, cmp_sel);
      end
      tick();
      // Squashed slot: a not-ready bne here must be ignored
      set_in(1'b1, 32'h0040_0014, 3'd2, 26'h0008, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (redirect !== 1'b1 || pc_target !== 32'h0040_0024) begin
         errors++;
         $display("FAIL beq_redirect: redirect=%b pc_target=%h expected 1 00400024", redirect, pc_target);
      end
      checks++;
      if (stall_id !== 1'b0) begin
         errors++;
         $display("FAIL squash_stall: stall_id=%b expected 0", stall_id);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b0 || stall_id !== 1'b0) begin
         errors++;
         $display("FAIL beq_one_cycle: redirect=%b stall_id=%b expected 0 0", redirect, stall_id);
      end
      checks++;
      if (br_count !== exp_br_cnt() || taken_count !== exp_taken_cnt()) begin
         errors++;
         $display("FAIL beq_counts: br=%0d taken=%0d expected %0d %0d",
                  br_count, taken_count, exp_br_cnt(), exp_taken_cnt());
      end
   endtask

   task automatic test_bne_not_taken();
      set_in(1'b1, 32'h0000_2000, 3'd2, 26'h0010, 1'b1, 1'b1, 1'b0, 1'b0);
      m_br++;
      #1;
      checks++;
      if (stall_id !== 1'b0) begin
         errors++;
         $display("FAIL bne_stall: stall_id=%b expected 0", stall_id);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b0) begin
         errors++;
         $display("FAIL bne_redirect: redirect=%b expected 0", redirect);
      end
      checks++;
      if (br_count !== exp_br_cnt() || taken_count !== exp_taken_cnt()) begin
         errors++;
         $display("FAIL bne_counts: br=%0d taken=%0d expected %0d %0d",
                  br_count, taken_count, exp_br_cnt(), exp_taken_cnt());
      end
      tick();
   endtask

   task automatic test_bgez_wait();
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 32'h0000_1000, 3'd4, 26'h0010, 1'b0, 1'b0, 1'b0, 1'b1);
         #1;
         checks++;
         if (stall_id !== 1'b1 || cmp_sel !== 1'b1 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL bgez_wait_%0d: stall_id=%b cmp_sel=%b redirect=%b expected 1 1 0",
                     i, stall_id, cmp_sel, redirect);
         end
         tick();
      end
      set_in(1'b1, 32'h0000_1000, 3'd4, 26'h0010, 1'b1, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(32'h0000_1044);
      m_br++;
      m_taken++;
      #1;
      checks++;
      if (stall_id !== 1'b0 || cmp_sel !== 1'b1) begin
         errors++;
         $display("FAIL bgez_ready: stall_id=%b cmp_sel=%b expected 0 1", stall_id, cmp_sel);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b1 || pc_target !== 32'h0000_1044 || hazard_err !== 1'b0) begin
         errors++;
         $display("FAIL bgez_redirect: redirect=%b pc_target=%h hazard=%b expected 1 00001044 0",
                  redirect, pc_target, hazard_err);
      end
      tick();
      tick();
   endtask

   task automatic test_jump_and_wrap();
      // Jump ignores ops_ready
      set_in(1'b1, 32'hF000_0000, 3'd5, 26'h0000100, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'hF000_0400);
      #1;
      checks++;
      if (stall_id !== 1'b0) begin
         errors++;
         $display("FAIL jump_stall: stall_id=%b expected 0", stall_id);
      end
      tick();
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b1 || pc_target !== 32'hF000_0400) begin
         errors++;
         $display("FAIL jump_target: redirect=%b pc_target=%h expected 1 f0000400", redirect, pc_target);
      end
      tick();
      set_in(1'b1, 32'h0000_0000, 3'd1, 26'h000FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(32'h0000_0000);
      m_br++;
      m_taken++;
      tick();
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b1 || pc_target !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_target: redirect=%b pc_target=%h expected 1 00000000", redirect, pc_target);
      end
      checks++;
      if (br_count !== exp_br_cnt() || taken_count !== exp_taken_cnt()) begin
         errors++;
         $display("FAIL jump_counts: br=%0d taken=%0d expected %0d %0d",
                  br_count, taken_count, exp_br_cnt(), exp_taken_cnt());
      end
      tick();
   endtask

   task automatic test_wait_flush();
      set_in(1'b1, 32'h0000_3000, 3'd2, 26'h0020, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      // External flush while waiting; operands then appear with a taken condition
      set_in(1'b0, 32'h0000_3000, 3'd2, 26'h0020, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b0 || stall_id !== 1'b0) begin
         errors++;
         $display("FAIL wait_flush: redirect=%b stall_id=%b expected 0 0", redirect, stall_id);
      end
      checks++;
      if (br_count !== exp_br_cnt()) begin
         errors++;
         $display("FAIL flush_counts: br=%0d expected %0d", br_count, exp_br_cnt());
      end
      tick();
   endtask

   task automatic test_hazard();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 32'h0000_4000, 3'd3, 26'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         if (i == 3) begin
            checks++;
            if (hazard_err !== 1'b0) begin
               errors++;
               $display("FAIL hazard_early: hazard_err=%b expected 0 after WAIT_MAX waits", hazard_err);
            end
         end
         tick();
      end
      checks++;
      if (hazard_err !== 1'b1) begin
         errors++;
         $display("FAIL hazard_set: hazard_err=%b expected 1", hazard_err);
      end
      set_in(1'b1, 32'h0000_4000, 3'd3, 26'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      m_br++;
      #1;
      checks++;
      if (stall_id !== 1'b0) begin
         errors++;
         $display("FAIL hazard_release: stall_id=%b expected 0", stall_id);
      end
      tick();
      idle_in();
      tick();
      tick();
      tick();
      checks++;
      if (hazard_err !== 1'b1 || br_count !== exp_br_cnt()) begin
         errors++;
         $display("FAIL hazard_sticky: hazard=%b br=%0d expected 1 %0d", hazard_err, br_count, exp_br_cnt());
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_br = 0;
      m_taken = 0;
      checks++;
      if (hazard_err !== 1'b0 || br_count !== exp_br_cnt() || taken_count !== exp_taken_cnt()) begin
         errors++;
         $display("FAIL hazard_clear: hazard=%b br=%0d taken=%0d expected 0 0 0",
                  hazard_err, br_count, taken_count);
      end
      tick();
   endtask

   task automatic test_rst_in_resolve();
      set_in(1'b1, 32'h0040_0010, 3'd1, 26'h0004, 1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_br = 0;
      m_taken = 0;
      idle_in();
      #1;
      checks++;
      if (redirect !== 1'b0 || flush_ifid !== 1'b0 || pc_target !== 32'd0) begin
         errors++;
         $display("FAIL rst_resolve: redirect=%b flush=%b pc_target=%h expected 0 0 0",
                  redirect, flush_ifid, pc_target);
      end
      tick();
      // Reset during WAIT: nothing pending afterwards
      set_in(1'b1, 32'h0000_5000, 3'd1, 26'h0004, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_in();
      #1;
      checks++;
      if (stall_id !== 1'b0 || redirect !== 1'b0 || br_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_wait: stall_id=%b redirect=%b br=%0d expected 0 0 0", stall_id, redirect, br_count);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic        skip;
      logic        tk;
      logic [31:0] pc;
      logic [25:0] j;
      logic [2:0]  t;
      logic        z, o, c;
      skip = 1'b0;
      for (int n = 0; n < 40; n++) begin
         pc = $urandom;
         j  = 26'($urandom);
         t  = 3'($urandom_range(0, 7));
         z  = 1'($urandom_range(0, 1));
         o  = 1'($urandom_range(0, 1));
         c  = 1'($urandom_range(0, 1));
         set_in(1'b1, pc, t, j, 1'b1, z, o, c);
         #1;
         checks++;
         if (stall_id !== 1'b0 || cmp_sel !== (t == 3'd4)) begin
            errors++;
            $display("FAIL b2b_comb_%0d: stall_id=%b cmp_sel=%b br_type=%0d", n, stall_id, cmp_sel, t);
         end
         if (skip) begin
            skip = 1'b0;
         end else if (t >= 3'd1 && t <= 3'd4) begin
            m_br++;
            tk = (t == 3'd1) ? z : (t == 3'd2) ? o : c;
            if (tk) begin
               m_taken++;
               exp_q.push_back(model_br_tgt(pc, j[15:0]));
            end
            skip = tk;
         end else if (t == 3'd5) begin
            exp_q.push_back(model_j_tgt(pc, j));
            skip = 1'b1;
         end
         tick();
      end
      idle_in();
      tick();
      tick();
      checks++;
      if (br_count !== exp_br_cnt() || taken_count !== exp_taken_cnt()) begin
         errors++;
         $display("FAIL b2b_counts: br=%0d taken=%0d expected %0d %0d",
                  br_count, taken_count, exp_br_cnt(), exp_taken_cnt());
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      idle_in();
      test_reset();
      test_beq_taken();
      test_bne_not_taken();
      test_bgez_wait();
      test_jump_and_wrap();
      test_wait_flush();
      test_hazard();
      test_rst_in_resolve();
      test_back_to_back();
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected redirects never seen, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
